// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and stream framing constants for the imem loader
package loader_pkg;
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR} state_t;
    localparam int LEN_BYTES = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/word_packer.sv
// word_packer: packs big-endian bytes into 32-bit words with a word-complete strobe
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);
    logic [23:0] sr;
    logic [1:0]  cnt;
    assign word_done = push && cnt == 2'(BYTES_PER_WORD - 1);
    assign word = {sr, byte_in};
    always_ff @(posedge clk) begin
        if (clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (push) begin
            sr  <= {sr[15:0], byte_in};
            cnt <= cnt + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: checksummed byte-stream loader writing the instruction memory and holding the CPU
module imem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 8,
    parameter int BASE_ADDR   = 0
) (
    input  logic              clk_LDR,
    input  logic              rst_LDR,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wrEnable,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [31:0]       wrData,
    output logic              cpuHold,
    output logic              done,
    output logic              error,
    output logic [6:0]        loadCount
);
    state_t state, state_nxt;
    logic [7:0]             len_hi, chk;
    logic [8*LEN_BYTES-1:0] n_len, n_rx;
    logic                   fire, restart, push, word_done, last_word;
    logic [31:0]            word;
    logic [ADDR_W-1:0]      addr_nxt;
    assign byte_ready = state inside {LEN_HI, LEN_LO, DATA, CHECK};
    assign done       = state == DONE;
    assign error      = state == ERROR;
    assign cpuHold    = state != DONE;
    assign fire       = byte_valid && byte_ready;
    assign restart    = start && state inside {IDLE, DONE, ERROR};
    assign push       = fire && state == DATA;
    assign n_rx       = {len_hi, byte_data};
    assign last_word  = word_done && (16'(loadCount) + 16'd1 == n_len);
    assign addr_nxt   = ADDR_W'(BASE_ADDR) + ADDR_W'({loadCount, 2'b00});
    word_packer u_packer (
        .clk       (clk_LDR),
        .clear     (rst_LDR || restart),
        .push      (push),
        .byte_in   (byte_data),
        .word      (word),
        .word_done (word_done)
    );
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: state_nxt = restart ? LEN_HI : state;
            LEN_HI:            state_nxt = fire ? LEN_LO : state;
            LEN_LO:            state_nxt = !fire ? state :
                                           n_rx > 16'(DEPTH_WORDS) ? ERROR :
                                           n_rx == '0 ? CHECK : DATA;
            DATA:              state_nxt = last_word ? CHECK : state;
            CHECK:             state_nxt = !fire ? state : byte_data == chk ? DONE : ERROR;
            default:           state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk_LDR) begin
        if (rst_LDR) begin
            state     <= IDLE;
            len_hi    <= '0;
            n_len     <= '0;
            chk       <= '0;
            loadCount <= '0;
            wrEnable  <= 1'b0;
            wrAddr    <= ADDR_W'(BASE_ADDR);
            wrData    <= '0;
        end else begin
            state    <= state_nxt;
            wrEnable <= word_done;
            if (restart) begin
                chk       <= '0;
                loadCount <= '0;
            end
            if (fire && state == LEN_HI) len_hi <= byte_data;
            if (fire && state == LEN_LO) n_len <= n_rx;
            if (push) chk <= chk ^ byte_data;
            if (word_done) begin
                wrAddr    <= addr_nxt;
                wrData    <= word;
                loadCount <= loadCount + 7'd1;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench against a stream-level loader model
module tb_imem_loader;
    logic        clk_LDR = 1'b0;
    logic        rst_LDR, start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, wrEnable, cpuHold, done, error;
    logic [7:0]  wrAddr;
    logic [31:0] wrData;
    logic [6:0]  loadCount;
    int          total = 0, bad = 0;
    logic [39:0] wq[$], eq[$];
    logic [7:0]  bq[$];
    logic        exp_done, exp_err;
    int          exp_cnt;

    imem_loader #(.DEPTH_WORDS(64), .ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk_LDR(clk_LDR), .rst_LDR(rst_LDR), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .wrEnable(wrEnable), .wrAddr(wrAddr),
        .wrData(wrData), .cpuHold(cpuHold), .done(done), .error(error), .loadCount(loadCount)
    );

    always #5 clk_LDR = ~clk_LDR;

    always @(negedge clk_LDR) if (wrEnable === 1'b1) wq.push_back({wrAddr, wrData});

    task automatic model();
        int n;
        logic [7:0] x;
        eq.delete();
        x = 8'h00;
        n = {bq[0], bq[1]};
        if (n > 64) begin
            exp_err = 1'b1; exp_done = 1'b0; exp_cnt = 0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            eq.push_back({8'(4 * i), bq[2+4*i], bq[3+4*i], bq[4+4*i], bq[5+4*i]});
            for (int j = 0; j < 4; j++) x = x ^ bq[2+4*i+j];
        end
        exp_cnt = n;
        exp_done = bq[2+4*n] == x;
        exp_err = !exp_done;
    endtask

    function automatic bit writes_ok();
        if (wq.size() != eq.size()) return 1'b0;
        foreach (eq[i]) if (wq[i] !== eq[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk_LDR); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit inj);
        int k = 0;
        byte_valid = 1'b1;
        byte_data = b;
        while (byte_ready !== 1'b1 && k < 20) begin
            @(posedge clk_LDR); #1;
            k++;
        end
        if (byte_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL handshake_timeout: byte_ready=%b required 1", byte_ready);
        end
        @(posedge clk_LDR); #1;
        byte_valid = 1'b0;
        byte_data = 8'($urandom);
        for (int g = 0; g < gap; g++) begin
            start = inj && g == 0;
            @(posedge clk_LDR); #1;
        end
        start = 1'b0;
    endtask

    task automatic good_stream(input logic [7:0] c);
        bq = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
        bq.push_back(c);
    endtask

    task automatic test_reset();
        rst_LDR = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(posedge clk_LDR);
        #1 rst_LDR = 1'b0;
        total += 7;
        if (cpuHold !== 1'b1) begin bad++; $display("FAIL reset_cpuHold: got %b required 1", cpuHold); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", done); end
        if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b required 0", error); end
        if (wrEnable !== 1'b0) begin bad++; $display("FAIL reset_wrEnable: got %b required 0", wrEnable); end
        if (byte_ready !== 1'b0) begin bad++; $display("FAIL reset_byte_ready: got %b required 0", byte_ready); end
        if (loadCount !== 7'd0) begin bad++; $display("FAIL reset_loadCount: got %0d required 0", loadCount); end
        if (wrAddr !== 8'h00 || wrData !== 32'h0) begin bad++; $display("FAIL reset_wr: got %h/%h required 00/00000000", wrAddr, wrData); end
    endtask

    task automatic test_good_load();
        good_stream(8'h0E);
        model();
        wq.delete();
        pulse_start();
        total++;
        if (cpuHold !== 1'b1 || byte_ready !== 1'b1) begin bad++; $display("FAIL good_loading: cpuHold=%b byte_ready=%b required 1/1", cpuHold, byte_ready); end
        foreach (bq[i]) begin
            send_byte(bq[i], 0, 1'b0);
            if (i == 5) begin
                total++;
                if (wrEnable !== 1'b1 || wrAddr !== 8'h00 || wrData !== 32'h20080005) begin
                    bad++; $display("FAIL good_latency: got we=%b %h:%h required 1 00:20080005", wrEnable, wrAddr, wrData);
                end
            end
            if (i == 6) begin
                total++;
                if (wrEnable !== 1'b0) begin bad++; $display("FAIL good_pulse: wrEnable=%b required 0", wrEnable); end
            end
        end
        total += 4;
        if (!writes_ok()) begin bad++; $display("FAIL good_writes: got %0d words required %0d", wq.size(), eq.size()); end
        if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL good_status: done=%b error=%b required 1/0", done, error); end
        if (cpuHold !== 1'b0) begin bad++; $display("FAIL good_cpuHold: got %b required 0", cpuHold); end
        if (loadCount !== 7'd2) begin bad++; $display("FAIL good_loadCount: got %0d required 2", loadCount); end
    endtask

    task automatic test_bad_checksum();
        good_stream(8'h0F);
        model();
        wq.delete();
        pulse_start();
        total++;
        if (done !== 1'b0 || cpuHold !== 1'b1) begin bad++; $display("FAIL restart_from_done: done=%b cpuHold=%b required 0/1", done, cpuHold); end
        foreach (bq[i]) send_byte(bq[i], 0, 1'b0);
        total += 3;
        if (!writes_ok()) begin bad++; $display("FAIL badsum_writes: got %0d words required %0d", wq.size(), eq.size()); end
        if (error !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL badsum_status: error=%b done=%b required 1/0", error, done); end
        if (cpuHold !== 1'b1) begin bad++; $display("FAIL badsum_cpuHold: got %b required 1", cpuHold); end
    endtask

    task automatic test_oversize();
        bq = {8'h00, 8'h41};
        wq.delete();
        pulse_start();
        foreach (bq[i]) send_byte(bq[i], 0, 1'b0);
        total += 3;
        if (error !== 1'b1) begin bad++; $display("FAIL oversize_error: got %b required 1", error); end
        if (byte_ready !== 1'b0) begin bad++; $display("FAIL oversize_ready: got %b required 0", byte_ready); end
        if (wq.size() != 0 || loadCount !== 7'd0) begin bad++; $display("FAIL oversize_writes: got %0d words count %0d required 0/0", wq.size(), loadCount); end
    endtask

    task automatic test_gaps();
        good_stream(8'h0E);
        model();
        wq.delete();
        pulse_start();
        foreach (bq[i]) send_byte(bq[i], 3, i == 4);
        total += 3;
        if (!writes_ok()) begin bad++; $display("FAIL gaps_writes: got %0d words required %0d", wq.size(), eq.size()); end
        if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL gaps_status: done=%b error=%b required 1/0", done, error); end
        if (loadCount !== 7'd2) begin bad++; $display("FAIL gaps_loadCount: got %0d required 2", loadCount); end
    endtask

    task automatic test_reset_mid();
        bq = {8'h00, 8'h02};
        repeat (5) bq.push_back(8'($urandom));
        wq.delete();
        pulse_start();
        foreach (bq[i]) send_byte(bq[i], 0, 1'b0);
        rst_LDR = 1'b1;
        @(posedge clk_LDR); #1;
        rst_LDR = 1'b0;
        total += 2;
        if (byte_ready !== 1'b0 || wrEnable !== 1'b0 || loadCount !== 7'd0 || cpuHold !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL midreset_state: ready=%b we=%b count=%0d hold=%b done=%b required 0/0/0/1/0", byte_ready, wrEnable, loadCount, cpuHold, done);
        end
        repeat (3) @(posedge clk_LDR);
        #1;
        if (wq.size() != 1 || wq[0] !== {8'h00, bq[2], bq[3], bq[4], bq[5]}) begin
            bad++; $display("FAIL midreset_writes: got %0d words required 1 of %h", wq.size(), {8'h00, bq[2], bq[3], bq[4], bq[5]});
        end
        bq = {8'h00, 8'h00, 8'h00};
        wq.delete();
        pulse_start();
        foreach (bq[i]) send_byte(bq[i], 0, 1'b0);
        total += 2;
        if (done !== 1'b1 || loadCount !== 7'd0) begin bad++; $display("FAIL empty_status: done=%b count=%0d required 1/0", done, loadCount); end
        if (wq.size() != 0) begin bad++; $display("FAIL empty_writes: got %0d words required 0", wq.size()); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            int n;
            logic [7:0] x;
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(65, 300) : $urandom_range(0, 9);
            bq = {8'(n >> 8), 8'(n)};
            x = 8'h00;
            if (n <= 64) begin
                for (int i = 0; i < 4 * n; i++) begin
                    bq.push_back(8'($urandom));
                    x = x ^ bq[bq.size()-1];
                end
                bq.push_back(($urandom_range(0, 2) == 0) ? x ^ 8'($urandom_range(1, 255)) : x);
            end
            model();
            wq.delete();
            pulse_start();
            foreach (bq[i]) send_byte(bq[i], $urandom_range(0, 2), 1'b0);
            total += 4;
            if (!writes_ok()) begin bad++; $display("FAIL rand%0d_writes: got %0d words required %0d", t, wq.size(), eq.size()); end
            if (done !== exp_done || error !== exp_err) begin bad++; $display("FAIL rand%0d_status: done=%b error=%b required %b/%b", t, done, error, exp_done, exp_err); end
            if (cpuHold !== !exp_done) begin bad++; $display("FAIL rand%0d_cpuHold: got %b required %b", t, cpuHold, !exp_done); end
            if (loadCount !== 7'(exp_cnt)) begin bad++; $display("FAIL rand%0d_loadCount: got %0d required %0d", t, loadCount, exp_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_oversize();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
